fisr_controller: RTL and testbench

FISR_CONTROLLER -- requirements
Module: fisr_controller

---
 rtl/fisr_controller.sv | 205 ++++++++++++++++++++
 tb/tb_fisr_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fisr_controller.sv
// Fast inverse square root sequencer: seeds y from the bit pattern of x and
// runs Newton steps on shared external FP multiplier/subtractor units.
module fisr_controller #(
    parameter int MUL_LAT = 3,
    parameter int SUB_LAT = 4,
    parameter int ITER    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] y_out,
    output logic        op_valid,
    output logic        op_mul,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] res_in
);

    // state  | meaning
    // IDLE   | waiting for start; captures x and forms the seed
    // ISSUE  | one-cycle op_valid strobe to the FP unit
    // WAIT   | counting down the unit latency; samples res_in on expiry
    // DONE   | one-cycle done pulse with y_out valid
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] MAGIC      = 32'h5F3759DF;
    localparam logic [31:0] HALF       = 32'h3F000000;
    localparam logic [31:0] THREE_HALF = 32'h3FC00000;
    localparam logic [31:0] POS_INF    = 32'h7F800000;
    localparam logic [31:0] QNAN       = 32'h7FC00000;

    localparam int LAT_MAX = (MUL_LAT > SUB_LAT) ? MUL_LAT : SUB_LAT;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);

    // step 4 is the one-off h = x*0.5 op; steps 0..3 form one Newton iteration
    localparam logic [2:0] STEP_SEED = 3'd4;
    localparam logic [1:0] ITER_LAST = 2'(ITER - 1);

    state_t           state, state_nx;
    logic [2:0]       step, step_nx;
    logic [1:0]       iter, iter_nx;
    logic [LAT_W-1:0] lat, lat_nx;
    logic [31:0]      x, x_nx;
    logic [31:0]      h, h_nx;
    logic [31:0]      y, y_nx;
    logic [31:0]      t, t_nx;
    logic [31:0]      y_out_nx;
    logic             op_valid_nx;
    logic             op_mul_nx;
    logic [31:0]      op_a_nx;
    logic [31:0]      op_b_nx;
    logic             last_op;

    assign last_op = (step == 3'd3) && (iter == ITER_LAST);

    always_comb begin
        state_nx = state;
        step_nx  = step;
        iter_nx  = iter;
        lat_nx   = lat;
        x_nx     = x;
        h_nx     = h;
        y_nx     = y;
        t_nx     = t;
        y_out_nx = y_out;

        case (state)
            S_IDLE: begin
                if (start) begin
                    x_nx    = x_in;
                    y_nx    = MAGIC - {1'b0, x_in[31:1]};
                    step_nx = STEP_SEED;
                    iter_nx = 2'd0;
                    if (x_in[30:0] == 31'd0) begin
                        y_out_nx = POS_INF;
                        state_nx = S_DONE;
                    end else if (x_in[31]) begin
                        y_out_nx = QNAN;
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
                lat_nx   = (step == 3'd2) ? LAT_W'(SUB_LAT) : LAT_W'(MUL_LAT);
            end
            S_WAIT: begin
                if (lat == LAT_W'(1)) begin
                    case (step)
                        STEP_SEED: h_nx = res_in;
                        3'd3:      y_nx = res_in;
                        default:   t_nx = res_in;
                    endcase
                    if (last_op) begin
                        y_out_nx = res_in;
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ISSUE;
                        if (step == STEP_SEED || step == 3'd3) begin
                            step_nx = 3'd0;
                        end else begin
                            step_nx = step + 3'd1;
                        end
                        if (step == 3'd3) begin
                            iter_nx = iter + 2'd1;
                        end
                    end
                end else begin
                    lat_nx = lat - LAT_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operands come from the post-update register values so a result sampled
    // on this edge can be forwarded straight into the next issue.
    always_comb begin
        op_valid_nx = (state_nx == S_ISSUE);
        op_mul_nx   = 1'b0;
        op_a_nx     = 32'd0;
        op_b_nx     = 32'd0;
        if (op_valid_nx) begin
            case (step_nx)
                STEP_SEED: begin
                    op_mul_nx = 1'b1;
                    op_a_nx   = x_nx;
                    op_b_nx   = HALF;
                end
                3'd0: begin
                    op_mul_nx = 1'b1;
                    op_a_nx   = y_nx;
                    op_b_nx   = y_nx;
                end
                3'd1: begin
                    op_mul_nx = 1'b1;
                    op_a_nx   = h_nx;
                    op_b_nx   = t_nx;
                end
                3'd2: begin
                    op_mul_nx = 1'b0;
                    op_a_nx   = THREE_HALF;
                    op_b_nx   = t_nx;
                end
                default: begin
                    op_mul_nx = 1'b1;
                    op_a_nx   = y_nx;
                    op_b_nx   = t_nx;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            step     <= 3'd0;
            iter     <= 2'd0;
            lat      <= '0;
            x        <= 32'd0;
            h        <= 32'd0;
            y        <= 32'd0;
            t        <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            y_out    <= 32'd0;
            op_valid <= 1'b0;
            op_mul   <= 1'b0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
        end else begin
            state    <= state_nx;
            step     <= step_nx;
            iter     <= iter_nx;
            lat      <= lat_nx;
            x        <= x_nx;
            h        <= h_nx;
            y        <= y_nx;
            t        <= t_nx;
            busy     <= (state_nx != S_IDLE);
            done     <= (state_nx == S_DONE);
            y_out    <= y_out_nx;
            op_valid <= op_valid_nx;
            op_mul   <= op_mul_nx;
            op_a     <= op_a_nx;
            op_b     <= op_b_nx;
        end
    end

endmodule

// File: tb/tb_fisr_controller.sv
// Randomized bench for fisr_controller: two instances (ITER=1 and ITER=2),
// behavioural FP units on res_in and a plain-arithmetic golden model.
module tb_fisr_controller;

    localparam int MUL_LAT = 3;
    localparam int SUB_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0;
    logic        start1;
    logic [31:0] x_in;
    logic        sel;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] b);
        if (b[30:23] == 8'd0) return 0.0;
        return $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] to_sp(input real r);
        logic [63:0] d;
        int          e;
        logic [23:0] m;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        m = {1'b0, d[51:29]} + {23'd0, d[28]};
        if (m[23]) begin
            e++;
            m = 24'd0;
        end
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return to_sp(to_real(a) * to_real(b));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return to_sp(to_real(a) - to_real(b));
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] x, input int iters);
        logic [31:0] h, y, t;
        if (x[30:0] == 31'd0) return 32'h7F800000;
        if (x[31]) return 32'h7FC00000;
        h = fmul(x, 32'h3F000000);
        y = 32'h5F3759DF - (x >> 1);
        for (int i = 0; i < iters; i++) begin
            t = fmul(y, y);
            t = fmul(h, t);
            t = fsub(32'h3FC00000, t);
            y = fmul(y, t);
        end
        return y;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        busy, done, op_valid, op_mul;
        logic [31:0] y_out, op_a, op_b, res_in;
        int          op_cnt;
        int          done_cnt;
        int          viol;
        logic [31:0] a_log[$];

        fisr_controller #(
            .MUL_LAT(MUL_LAT),
            .SUB_LAT(SUB_LAT),
            .ITER   (g + 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   ((g == 0) ? start0 : start1),
            .x_in    (x_in),
            .busy    (busy),
            .done    (done),
            .y_out   (y_out),
            .op_valid(op_valid),
            .op_mul  (op_mul),
            .op_a    (op_a),
            .op_b    (op_b),
            .res_in  (res_in)
        );

        initial begin : mon
            done_cnt = 0;
            viol = 0;
            forever begin
                @(negedge clk);
                if (done) done_cnt++;
                if (!op_valid && (op_mul || op_a != 32'd0 || op_b != 32'd0)) viol++;
                if (op_valid && !busy) viol++;
            end
        end

        // FP unit: result is driven only in the cycle it is due, garbage otherwise
        initial begin : unit
            logic [31:0] r;
            int          lat;
            op_cnt = 0;
            res_in = 32'hDEADBEEF;
            forever begin
                @(negedge clk);
                if (op_valid) begin
                    op_cnt++;
                    a_log.push_back(op_a);
                    r   = op_mul ? fmul(op_a, op_b) : fsub(op_a, op_b);
                    lat = op_mul ? MUL_LAT : SUB_LAT;
                    @(posedge clk);
                    repeat (lat - 1) @(posedge clk);
                    #1 res_in = r;
                    @(posedge clk);
                    #1 res_in = $urandom;
                end
            end
        end
    end

    logic        busy_m, done_m, opv_m, opm_m;
    logic [31:0] y_m, opa_m, opb_m;
    int          opcnt_m, donecnt_m;

    assign busy_m    = sel ? g_dut[1].busy     : g_dut[0].busy;
    assign done_m    = sel ? g_dut[1].done     : g_dut[0].done;
    assign opv_m     = sel ? g_dut[1].op_valid : g_dut[0].op_valid;
    assign opm_m     = sel ? g_dut[1].op_mul   : g_dut[0].op_mul;
    assign y_m       = sel ? g_dut[1].y_out    : g_dut[0].y_out;
    assign opa_m     = sel ? g_dut[1].op_a     : g_dut[0].op_a;
    assign opb_m     = sel ? g_dut[1].op_b     : g_dut[0].op_b;
    assign opcnt_m   = sel ? g_dut[1].op_cnt   : g_dut[0].op_cnt;
    assign donecnt_m = sel ? g_dut[1].done_cnt : g_dut[0].done_cnt;

    task automatic set_start(input bit s, input logic v);
        if (s) start1 = v;
        else   start0 = v;
    endtask

    function automatic logic [31:0] rand_x();
        return {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic run(input bit s, input logic [31:0] x, input bit inject);
        int          iters, n, exp_lat, exp_ops, ops0, dones0;
        logic [31:0] exp_y, seed_a;
        bit          special, seen;
        iters   = s ? 2 : 1;
        special = (x[30:0] == 31'd0) || x[31];
        exp_y   = golden(x, iters);
        exp_lat = special ? 1 : 1 + (1 + MUL_LAT) + iters * (3 * (1 + MUL_LAT) + (1 + SUB_LAT));
        exp_ops = special ? 0 : 1 + 4 * iters;
        sel = s;
        @(negedge clk);
        #2;
        ops0   = opcnt_m;
        dones0 = donecnt_m;
        x_in   = x;
        set_start(s, 1'b1);
        @(posedge clk);
        #1 set_start(s, 1'b0);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done_m) begin
                seen = 1'b1;
            end else begin
                if (inject && (n == 5 || n == 21)) begin
                    x_in = $urandom;
                    set_start(s, 1'b1);
                end
                @(posedge clk);
                #1 set_start(s, 1'b0);
                n++;
            end
        end
        check("latency", seen ? n : -1, exp_lat);
        check("y_out", y_m, exp_y);
        check("busy_in_done", {31'd0, busy_m}, 32'd1);
        check("op_count", opcnt_m - ops0, exp_ops);
        if (!special) begin
            seed_a = s ? g_dut[1].a_log[ops0 + 1] : g_dut[0].a_log[ops0 + 1];
            check("seed_op_a", seed_a, 32'h5F3759DF - (x >> 1));
        end
        @(negedge clk);
        check("done_pulse_end", {30'd0, done_m, busy_m}, 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("y_out_hold", y_m, exp_y);
        check("done_count", donecnt_m - dones0, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dones0;
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        x_in   = 32'd0;
        sel    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {28'd0, busy_m, done_m, opv_m, opm_m}, 32'd0);
        check("reset_y", y_m, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(1'b0, 32'h3F800000, 1'b0);
        run(1'b1, 32'h40800000, 1'b0);
        run(1'b0, 32'h00000000, 1'b0);
        run(1'b0, 32'hC0000000, 1'b0);
        run(1'b0, 32'h80000000, 1'b0);
        run(1'b1, 32'h80000001, 1'b0);
        run(1'b0, 32'h3F800000, 1'b1);
        run(1'b0, rand_x(), 1'b1);
        for (int i = 0; i < 8; i++) begin
            run(1'($urandom_range(0, 1)), rand_x(), 1'b0);
        end

        // reset in cycle 10 of a running operation
        sel = 1'b0;
        @(negedge clk);
        #2 dones0 = donecnt_m;
        x_in   = rand_x();
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_mid_ctrl", {28'd0, busy_m, done_m, opv_m, opm_m}, 32'd0);
        check("rst_mid_ops", opa_m | opb_m, 32'd0);
        check("rst_mid_y", y_m, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        #2 check("rst_no_done", donecnt_m - dones0, 0);
        run(1'b0, rand_x(), 1'b0);
        run(1'b1, rand_x(), 1'b0);

        check("op_gating0", g_dut[0].viol, 0);
        check("op_gating1", g_dut[1].viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
